// File: rtl/nibble_exec_if.sv
// Connection bundle between the fetch register / PC / ROM side and the
// nibble_exec execute stage.
interface nibble_exec_if;
  logic [3:0]  instr;
  logic [3:0]  oprnd;
  logic [7:0]  program_byte;
  logic [3:0]  data_in;
  logic        fetch_en;
  logic        pc_inc;
  logic        pc_load;
  logic [11:0] pc_target;
  logic [3:0]  accu;
  logic        c_flag;
  logic        z_flag;
  logic [3:0]  out_port;
  logic        out_we;

  modport master (
    output instr, oprnd, program_byte, data_in,
    input  fetch_en, pc_inc, pc_load, pc_target,
    input  accu, c_flag, z_flag, out_port, out_we
  );

  modport slave (
    input  instr, oprnd, program_byte, data_in,
    output fetch_en, pc_inc, pc_load, pc_target,
    output accu, c_flag, z_flag, out_port, out_we
  );
endinterface

// File: rtl/nibble_exec.sv
// Two-cycle FETCH/EXEC sequencer and 4-bit ALU with carry/zero flags,
// driving PC increment/load controls and the fetch-register enable.
module nibble_exec (
  input  logic          clk,
  input  logic          reset,
  nibble_exec_if.slave  bus
);

  typedef enum logic [0:0] {
    ST_FETCH = 1'b0,
    ST_EXEC  = 1'b1
  } state_e;

  localparam logic [3:0] OP_LIT  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_NAND = 4'h5;
  localparam logic [3:0] OP_CMP  = 4'h6;
  localparam logic [3:0] OP_IN   = 4'h7;
  localparam logic [3:0] OP_OUT  = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_JC   = 4'hA;
  localparam logic [3:0] OP_JNC  = 4'hB;
  localparam logic [3:0] OP_JZ   = 4'hC;
  localparam logic [3:0] OP_JNZ  = 4'hD;

  state_e      state_q, state_d;
  logic [3:0]  accu_q, accu_d;
  logic        c_q, c_d;
  logic        z_q, z_d;
  logic [3:0]  out_q, out_d;
  logic        out_we_q, out_we_d;

  logic        fetch_en_s;
  logic        pc_inc_s;
  logic        pc_load_s;
  logic [11:0] pc_target_s;
  logic        is_jump_s;
  logic        taken_s;
  logic [4:0]  sum_s;
  logic [4:0]  diff_s;

  // Bit 4 of the difference is the borrow, so carry after SUB/CMP is its inverse.
  assign sum_s  = {1'b0, accu_q} + {1'b0, bus.oprnd};
  assign diff_s = {1'b0, accu_q} - {1'b0, bus.oprnd};

  // Next-state, datapath update and PC/fetch control decode.
  always_comb begin
    state_d     = state_q;
    accu_d      = accu_q;
    c_d         = c_q;
    z_d         = z_q;
    out_d       = out_q;
    out_we_d    = 1'b0;
    fetch_en_s  = 1'b0;
    pc_inc_s    = 1'b0;
    pc_load_s   = 1'b0;
    pc_target_s = 12'h000;
    is_jump_s   = 1'b0;
    taken_s     = 1'b0;

    case (state_q)
      ST_FETCH: begin
        fetch_en_s = 1'b1;
        pc_inc_s   = 1'b1;
        state_d    = ST_EXEC;
      end
      ST_EXEC: begin
        state_d     = ST_FETCH;
        pc_target_s = {bus.oprnd, bus.program_byte};
        case (bus.instr)
          OP_LIT: begin
            accu_d = bus.oprnd;
            z_d    = (bus.oprnd == 4'h0);
          end
          OP_ADD: begin
            accu_d = sum_s[3:0];
            c_d    = sum_s[4];
            z_d    = (sum_s[3:0] == 4'h0);
          end
          OP_SUB: begin
            accu_d = diff_s[3:0];
            c_d    = ~diff_s[4];
            z_d    = (diff_s[3:0] == 4'h0);
          end
          OP_AND: begin
            accu_d = accu_q & bus.oprnd;
            z_d    = ((accu_q & bus.oprnd) == 4'h0);
          end
          OP_NAND: begin
            accu_d = ~(accu_q & bus.oprnd);
            z_d    = (~(accu_q & bus.oprnd) == 4'h0);
          end
          OP_CMP: begin
            c_d = ~diff_s[4];
            z_d = (diff_s[3:0] == 4'h0);
          end
          OP_IN: begin
            accu_d = bus.data_in;
            z_d    = (bus.data_in == 4'h0);
          end
          OP_OUT: begin
            out_d    = accu_q;
            out_we_d = 1'b1;
          end
          OP_JMP: begin
            is_jump_s = 1'b1;
            taken_s   = 1'b1;
          end
          OP_JC: begin
            is_jump_s = 1'b1;
            taken_s   = c_q;
          end
          OP_JNC: begin
            is_jump_s = 1'b1;
            taken_s   = ~c_q;
          end
          OP_JZ: begin
            is_jump_s = 1'b1;
            taken_s   = z_q;
          end
          OP_JNZ: begin
            is_jump_s = 1'b1;
            taken_s   = ~z_q;
          end
          default: begin
            accu_d = accu_q;
          end
        endcase
        // A reset arriving in EXEC suppresses any PC movement on that edge.
        if (is_jump_s && reset) begin
          pc_load_s = taken_s;
          pc_inc_s  = ~taken_s;
        end else begin
          pc_load_s = 1'b0;
          pc_inc_s  = 1'b0;
        end
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // State and architectural registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_FETCH;
      accu_q   <= 4'h0;
      c_q      <= 1'b0;
      z_q      <= 1'b0;
      out_q    <= 4'h0;
      out_we_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      accu_q   <= accu_d;
      c_q      <= c_d;
      z_q      <= z_d;
      out_q    <= out_d;
      out_we_q <= out_we_d;
    end
  end

  assign bus.fetch_en  = fetch_en_s;
  assign bus.pc_inc    = pc_inc_s;
  assign bus.pc_load   = pc_load_s;
  assign bus.pc_target = pc_target_s;
  assign bus.accu      = accu_q;
  assign bus.c_flag    = c_q;
  assign bus.z_flag    = z_q;
  assign bus.out_port  = out_q;
  assign bus.out_we    = out_we_q;

endmodule

// File: tb/tb_nibble_exec.sv
// Scoreboard bench for nibble_exec: directed instruction vectors push per-cycle
// expectations; a negedge monitor pops and compares.
module tb_nibble_exec;

  logic clk;
  logic reset;

  nibble_exec_if bus ();

  nibble_exec dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        fe;
    logic        inc;
    logic        ld;
    logic        chk_tgt;
    logic [11:0] tgt;
    logic [3:0]  accu;
    logic        c;
    logic        z;
    logic [3:0]  outp;
    logic        we;
  } exp_t;

  typedef struct {
    string      name;
    logic [3:0] instr;
    logic [3:0] oprnd;
    logic [7:0] pb;
    logic [3:0] din;
    logic       ld;
    logic       inc;
    logic [3:0] accu;
    logic       c;
    logic       z;
    logic [3:0] outp;
    logic       we;
    logic       rst_exec;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[$];

  int checks = 0;
  int errors = 0;

  logic [3:0] prev_accu;
  logic       prev_c, prev_z, prev_we;
  logic [3:0] prev_out;

  task automatic chk(input string nm, input string field, input logic [11:0] act, input logic [11:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s.%s: got %h expected %h", nm, field, act, expv);
    end
  endtask

  // Monitor: every cycle that has an expectation queued is compared here.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.name, "fetch_en", {11'd0, bus.fetch_en}, {11'd0, e.fe});
      chk(e.name, "pc_inc",   {11'd0, bus.pc_inc},   {11'd0, e.inc});
      chk(e.name, "pc_load",  {11'd0, bus.pc_load},  {11'd0, e.ld});
      if (e.chk_tgt) chk(e.name, "pc_target", bus.pc_target, e.tgt);
      chk(e.name, "accu",     {8'd0, bus.accu},      {8'd0, e.accu});
      chk(e.name, "c_flag",   {11'd0, bus.c_flag},   {11'd0, e.c});
      chk(e.name, "z_flag",   {11'd0, bus.z_flag},   {11'd0, e.z});
      chk(e.name, "out_port", {8'd0, bus.out_port},  {8'd0, e.outp});
      chk(e.name, "out_we",   {11'd0, bus.out_we},   {11'd0, e.we});
    end
  end

  function automatic void add(input string nm, input logic [3:0] ins, input logic [3:0] op,
                              input logic [7:0] pb, input logic [3:0] din, input logic ld,
                              input logic inc, input logic [3:0] acc, input logic c,
                              input logic z, input logic [3:0] outp, input logic we,
                              input logic rst_exec);
    vec_t v;
    v.name = nm; v.instr = ins; v.oprnd = op; v.pb = pb; v.din = din;
    v.ld = ld; v.inc = inc; v.accu = acc; v.c = c; v.z = z; v.outp = outp;
    v.we = we; v.rst_exec = rst_exec;
    vecs.push_back(v);
  endfunction

  task automatic run_instr(input vec_t v);
    exp_t e;
    bus.instr        = v.instr;
    bus.oprnd        = v.oprnd;
    bus.program_byte = 8'h00;
    bus.data_in      = v.din;
    e.name = {v.name, "/F"}; e.fe = 1'b1; e.inc = 1'b1; e.ld = 1'b0;
    e.chk_tgt = 1'b0; e.tgt = 12'h000;
    e.accu = prev_accu; e.c = prev_c; e.z = prev_z; e.outp = prev_out; e.we = prev_we;
    exp_q.push_back(e);
    @(posedge clk); #1;
    bus.program_byte = v.pb;
    if (v.rst_exec) reset = 1'b0;
    e.name = {v.name, "/E"}; e.fe = 1'b0; e.inc = v.inc; e.ld = v.ld;
    e.chk_tgt = 1'b1; e.tgt = {v.oprnd, v.pb}; e.we = 1'b0;
    exp_q.push_back(e);
    @(posedge clk); #1;
    reset = 1'b1;
    prev_accu = v.accu; prev_c = v.c; prev_z = v.z; prev_out = v.outp; prev_we = v.we;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //     name        ins    op     pb      din   ld    inc   accu  c     z     out   we    rst
    add("nop0",     4'h0, 4'h0, 8'h00, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    add("nop1",     4'h0, 4'h0, 8'h00, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    add("lit9",     4'h1, 4'h9, 8'h00, 4'h0, 1'b0, 1'b0, 4'h9, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    add("add8",     4'h2, 4'h8, 8'h00, 4'h0, 1'b0, 1'b0, 4'h1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    add("sub1",     4'h3, 4'h1, 8'h00, 4'h0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0);
    add("lit3",     4'h1, 4'h3, 8'h00, 4'h0, 1'b0, 1'b0, 4'h3, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    add("cmp5",     4'h6, 4'h5, 8'h00, 4'h0, 1'b0, 1'b0, 4'h3, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    add("jnc_t",    4'hB, 4'h4, 8'hA7, 4'h0, 1'b1, 1'b0, 4'h3, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    add("jz_nt",    4'hC, 4'h2, 8'h33, 4'h0, 1'b0, 1'b1, 4'h3, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    add("in6",      4'h7, 4'h0, 8'h00, 4'h6, 1'b0, 1'b0, 4'h6, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    add("out",      4'h8, 4'h0, 8'h00, 4'h0, 1'b0, 1'b0, 4'h6, 1'b0, 1'b0, 4'h6, 1'b1, 1'b0);
    add("nandF",    4'h5, 4'hF, 8'h00, 4'h0, 1'b0, 1'b0, 4'h9, 1'b0, 1'b0, 4'h6, 1'b0, 1'b0);
    add("add7ovf",  4'h2, 4'h7, 8'h00, 4'h0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 4'h6, 1'b0, 1'b0);
    add("jc_t",     4'hA, 4'h1, 8'h00, 4'h0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 4'h6, 1'b0, 1'b0);
    add("jnz_nt",   4'hD, 4'h5, 8'h5A, 4'h0, 1'b0, 1'b1, 4'h0, 1'b1, 1'b1, 4'h6, 1'b0, 1'b0);
    add("sub1unf",  4'h3, 4'h1, 8'h00, 4'h0, 1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 4'h6, 1'b0, 1'b0);
    add("jnz_t",    4'hD, 4'h2, 8'hBC, 4'h0, 1'b1, 1'b0, 4'hF, 1'b0, 1'b0, 4'h6, 1'b0, 1'b0);
    add("jc_nt",    4'hA, 4'h7, 8'h11, 4'h0, 1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 4'h6, 1'b0, 1'b0);
    add("and5",     4'h4, 4'h5, 8'h00, 4'h0, 1'b0, 1'b0, 4'h5, 1'b0, 1'b0, 4'h6, 1'b0, 1'b0);
    add("andA",     4'h4, 4'hA, 8'h00, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 4'h6, 1'b0, 1'b0);
    add("op_e",     4'hE, 4'h3, 8'h00, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 4'h6, 1'b0, 1'b0);
    add("jmp_rst",  4'h9, 4'hF, 8'hFF, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
    add("nop_post", 4'h0, 4'h0, 8'h00, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    add("lit0",     4'h1, 4'h0, 8'h00, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0);
    add("jmp_t",    4'h9, 4'hC, 8'h3D, 4'h0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0);
    add("nop_end",  4'hF, 4'h0, 8'h00, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0);

    prev_accu = 4'h0; prev_c = 1'b0; prev_z = 1'b0; prev_out = 4'h0; prev_we = 1'b0;
    bus.instr = 4'h0; bus.oprnd = 4'h0; bus.program_byte = 8'h00; bus.data_in = 4'h0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;

    foreach (vecs[i]) run_instr(vecs[i]);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nibble_exec.md
# nibble_exec

Execute stage and sequencer for the 4-bit processor, directly downstream of the fetch register. It consumes the latched `instr`/`oprnd` nibbles and the live ROM byte, and executes the instruction against a 4-bit accumulator with carry/zero flags. It drives the program counter controls (`pc_inc`, `pc_load`, `pc_target`) and the fetch-register enable, closing the fetch/execute loop.

## Interface
- No parameters. Widths are fixed by the 4-bit datapath and 12-bit PC.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous reset, active-low.
- `instr` in 4: opcode from the fetch register.
- `oprnd` in 4: operand from the fetch register.
- `program_byte` in 8: current ROM output at the present PC. Used as the low byte of a jump target.
- `data_in` in 4: input port, read by IN.
- `fetch_en` out 1: enable for the fetch register.
- `pc_inc` out 1: enable for PC increment.
- `pc_load` out 1: PC load strobe.
- `pc_target` out 12: PC load value.
- `accu` out 4: accumulator.
- `c_flag` out 1: carry flag.
- `z_flag` out 1: zero flag.
- `out_port` out 4: output register.
- `out_we` out 1: one-cycle pulse when `out_port` is written.

## Operation
- Two-state FSM: FETCH and EXEC. Each instruction takes exactly 2 cycles.
- FETCH:
  - `fetch_en=1`, `pc_inc=1`. The fetch register captures `ROM[PC]` while the PC advances on the same edge.
  - Next state is EXEC.
- EXEC:
  - Decode `instr` and update state.
  - `fetch_en=0`. `pc_inc`/`pc_load` are set per the jump rules below.
  - Next state is FETCH.
- Opcodes (`instr`):
  - 0000 NOP.
  - 0001 LIT: `accu<=oprnd`; Z updated.
  - 0010 ADD: `{C,accu}<=accu+oprnd`, 5-bit sum; C and Z updated.
  - 0011 SUB: `accu<=accu-oprnd` mod 16; `C=1` iff `accu>=oprnd` (no borrow); Z updated.
  - 0100 AND: `accu<=accu&oprnd`; Z updated.
  - 0101 NAND: `accu<=~(accu&oprnd)`; Z updated.
  - 0110 CMP: C and Z as for SUB; `accu` unchanged.
  - 0111 IN: `accu<=data_in`; Z updated.
  - 1000 OUT: `out_port<=accu`; `out_we=1` for the cycle after the EXEC edge. Flags unchanged.
  - 1001 JMP, 1010 JC, 1011 JNC, 1100 JZ, 1101 JNZ: two-byte instructions.
  - 1110, 1111: NOP.
- Z rule: Z equals 1 iff the new `accu` result (or the CMP difference) is 0. Flags are unchanged by opcodes not listed as updating them.
- Jumps, all evaluated in EXEC:
  - `program_byte` holds the second instruction byte, because the PC already advanced.
  - `pc_target={oprnd, program_byte}` is driven combinationally in every EXEC cycle.
  - Condition true (JMP always true; JC: C=1; JNC: C=0; JZ: Z=1; JNZ: Z=0): `pc_load=1`, `pc_inc=0`.
  - Condition false: `pc_load=0`, `pc_inc=1`, which skips the second byte.
- All non-jump EXEC cycles: `pc_inc=0`, `pc_load=0`.
- `pc_load` and `pc_inc` are never asserted together.

## Timing
- Reset (`reset=0` at a rising edge):
  - State goes to FETCH.
  - `accu=0`, `c_flag=0`, `z_flag=0`, `out_port=0`, `out_we=0`.
- First cycle after reset release: `fetch_en=1`, `pc_inc=1`, `pc_load=0`.
- Output kinds:
  - `fetch_en`, `pc_inc`, `pc_load`, `pc_target` are combinational from state, `instr`, `oprnd`, `program_byte`, and the flags.
  - `accu`, flags, `out_port`, `out_we` are registered.
- Latency: a result is visible on `accu`/flags in the FETCH cycle following its EXEC cycle.
- Flag forwarding: a conditional jump tests the flags as registered. Flags written by the instruction immediately before are already valid.
- Reset asserted during EXEC of a taken jump:
  - Reset wins; no state update.
  - The next cycle is FETCH with `pc_load=0`.
- ADD overflow wraps: 0xF+0x1 gives `accu=0`, C=1, Z=1.
- SUB underflow wraps: 0x0-0x1 gives `accu=0xF`, C=0, Z=0.

## Test plan
- Reset, then release: `fetch_en`/`pc_inc` alternate 1,0,1,0 on NOP stream; `accu=0`, flags 0 throughout.
- LIT 0x9, then ADD 0x8: `accu=0x1`, C=1, Z=0. Then SUB 0x1: `accu=0x0`, C=1, Z=1.
- LIT 0x3, CMP 0x5: `accu` stays 0x3, C=0, Z=0. Then JNC with `oprnd=0x4`, `program_byte=0xA7`: EXEC shows `pc_load=1`, `pc_target=0x4A7`, `pc_inc=0`.
- JZ with Z=0: `pc_load=0`, `pc_inc=1` in EXEC, so the PC advances by 2 total for the instruction.
- IN with `data_in=0x6`, then OUT: `out_port=0x6`, `out_we` high exactly one cycle. NAND 0xF on 0x6 gives `accu=0x9`.
- Pull `reset` low during EXEC of JMP: no `pc_load` on the following edge; `accu`/flags/`out_port` cleared; FETCH resumes after release.
